// File: rtl/os_tx_scheduler.sv
// Ordered-set / transport-data arbiter for the lane transmit bus; counts os_sent per burst and inserts an idle gap.
// Optional os_sent watchdog is built only when OS_TIMEOUT_EN is defined.
module os_tx_scheduler #(
    parameter int REP_W          = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             fsm_clk,
    input  logic             rst,
    input  logic [3:0]       os_req,
    input  logic [REP_W-1:0] os_rep,
    input  logic             data_req,
    input  logic             os_sent,
    output logic [3:0]       d_sel,
    output logic [3:0]       os_grant,
    output logic             os_done,
    output logic             data_active,
    output logic             busy,
    output logic             os_timeout
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    function automatic logic [3:0] lowest_bit(input logic [3:0] req);
        return req & (~req + 4'd1);
    endfunction

    function automatic logic [3:0] sel_code(input logic [3:0] onehot);
        logic [3:0] code;
        case (onehot)
            4'b0001: code = 4'd1;
            4'b0010: code = 4'd2;
            4'b0100: code = 4'd3;
            4'b1000: code = 4'd4;
            default: code = 4'd0;
        endcase
        return code;
    endfunction

    state_t           state_r, state_s;
    logic [REP_W-1:0] rep_cnt_r, rep_cnt_s;
    logic [GAP_W-1:0] gap_cnt_r, gap_cnt_s;
    logic             abort_r, abort_s;
    logic [3:0]       d_sel_r, d_sel_s;
    logic [3:0]       grant_r, grant_s;
    logic             done_r, done_s;
    logic             data_active_r, data_active_s;
    logic             busy_r, busy_s;
    logic             finish_s;
    logic [3:0]       win_s;
    logic             granted_live_s;

`ifdef OS_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_r, wd_cnt_s;
    logic            timeout_r, timeout_s;
`endif

    assign win_s          = lowest_bit(os_req);
    assign granted_live_s = ((os_req & grant_r) != 4'd0);

    // Next-state and next-output computation
    always_comb begin
        state_s   = state_r;
        rep_cnt_s = rep_cnt_r;
        gap_cnt_s = gap_cnt_r;
        abort_s   = abort_r;
        d_sel_s   = d_sel_r;
        grant_s   = grant_r;
        done_s    = 1'b0;
        finish_s  = 1'b0;
`ifdef OS_TIMEOUT_EN
        wd_cnt_s  = wd_cnt_r;
        timeout_s = timeout_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (os_req != 4'd0) begin
                    state_s   = ST_SEND;
                    grant_s   = win_s;
                    d_sel_s   = sel_code(win_s);
                    rep_cnt_s = (os_rep == '0) ? REP_ONE : os_rep;
                    abort_s   = 1'b0;
`ifdef OS_TIMEOUT_EN
                    wd_cnt_s  = '0;
`endif
                end else if (data_req) begin
                    state_s = ST_DATA;
                    d_sel_s = 4'd8;
                end else begin
                    d_sel_s = 4'd0;
                    grant_s = 4'd0;
                end
            end
            ST_SEND: begin
                // A dropped request is remembered so the set in flight still completes
                if (os_sent) begin
                    if ((rep_cnt_r == REP_ONE) || abort_r || !granted_live_s) begin
                        finish_s = 1'b1;
                    end else begin
                        rep_cnt_s = rep_cnt_r - REP_ONE;
                    end
`ifdef OS_TIMEOUT_EN
                    wd_cnt_s = '0;
`endif
                end else begin
                    abort_s = abort_r | !granted_live_s;
`ifdef OS_TIMEOUT_EN
                    if (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_s = 1'b1;
                        finish_s  = 1'b1;
                    end else begin
                        wd_cnt_s = wd_cnt_r + WD_W'(1);
                    end
`endif
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == '0) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r - GAP_W'(1);
                end
            end
            ST_DATA: begin
                if ((os_req != 4'd0) || !data_req) begin
                    state_s = ST_IDLE;
                    d_sel_s = 4'd0;
                end else begin
                    d_sel_s = 4'd8;
                end
            end
            default: begin
                state_s = ST_IDLE;
                d_sel_s = 4'd0;
                grant_s = 4'd0;
            end
        endcase

        if (finish_s) begin
            done_s    = 1'b1;
            d_sel_s   = 4'd0;
            grant_s   = 4'd0;
            rep_cnt_s = '0;
            abort_s   = 1'b0;
            gap_cnt_s = GAP_LOAD;
            state_s   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
`ifdef OS_TIMEOUT_EN
            wd_cnt_s  = '0;
`endif
        end else begin
            done_s = 1'b0;
        end

        busy_s        = (state_s != ST_IDLE);
        data_active_s = (d_sel_s == 4'd8);
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge fsm_clk) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            rep_cnt_r     <= '0;
            gap_cnt_r     <= '0;
            abort_r       <= 1'b0;
            d_sel_r       <= 4'd0;
            grant_r       <= 4'd0;
            done_r        <= 1'b0;
            data_active_r <= 1'b0;
            busy_r        <= 1'b0;
`ifdef OS_TIMEOUT_EN
            wd_cnt_r      <= '0;
            timeout_r     <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            rep_cnt_r     <= rep_cnt_s;
            gap_cnt_r     <= gap_cnt_s;
            abort_r       <= abort_s;
            d_sel_r       <= d_sel_s;
            grant_r       <= grant_s;
            done_r        <= done_s;
            data_active_r <= data_active_s;
            busy_r        <= busy_s;
`ifdef OS_TIMEOUT_EN
            wd_cnt_r      <= wd_cnt_s;
            timeout_r     <= timeout_s;
`endif
        end
    end

    assign d_sel       = d_sel_r;
    assign os_grant    = grant_r;
    assign os_done     = done_r;
    assign data_active = data_active_r;
    assign busy        = busy_r;
`ifdef OS_TIMEOUT_EN
    assign os_timeout  = timeout_r;
`else
    assign os_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_os_tx_scheduler.sv
// Self-checking bench for os_tx_scheduler: directed test-plan steps followed by randomized bursts
// checked against a transaction-level model (winner, code, sends-to-done, gap length).
module tb_os_tx_scheduler;
    localparam int REP_W = 8;
    localparam int GAP   = 2;
    localparam int TMO   = 64;

    logic             fsm_clk = 1'b0;
    logic             rst;
    logic [3:0]       os_req;
    logic [REP_W-1:0] os_rep;
    logic             data_req;
    logic             os_sent;
    logic [3:0]       d_sel;
    logic [3:0]       os_grant;
    logic             os_done;
    logic             data_active;
    logic             busy;
    logic             os_timeout;

    int compared   = 0;
    int mismatched = 0;

    os_tx_scheduler #(.REP_W(REP_W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .fsm_clk    (fsm_clk),
        .rst        (rst),
        .os_req     (os_req),
        .os_rep     (os_rep),
        .data_req   (data_req),
        .os_sent    (os_sent),
        .d_sel      (d_sel),
        .os_grant   (os_grant),
        .os_done    (os_done),
        .data_active(data_active),
        .busy       (busy),
        .os_timeout (os_timeout)
    );

    always #5 fsm_clk = ~fsm_clk;

    initial begin
        #2000000;
        $display("FAIL sim_timeout: run exceeded its time limit");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge fsm_clk);
            #1;
        end
    endtask

    task automatic pulse_sent();
        os_sent = 1'b1;
        tick(1);
        os_sent = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected: GAP idle cycles with busy high, then IDLE with busy low
    task automatic expect_gap(input string tag);
        for (int g = 1; g <= GAP; g++) begin
            tick(1);
            check({tag, "_gap_dsel"}, 32'(d_sel), 32'd0);
            check({tag, "_gap_done"}, 32'(os_done), 32'd0);
            check({tag, "_gap_busy"}, 32'(busy), (g < GAP) ? 32'd1 : 32'd0);
        end
    endtask

    function automatic int lowest_idx(input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    initial begin
        int idx;
        int need;
        int eff;
        int abort_at;
        logic [3:0] req;
        logic dreq;

        rst = 1'b0; os_req = 4'b0100; os_rep = '0; data_req = 1'b0; os_sent = 1'b0;

        // Reset held with a pending request
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_dsel", 32'(d_sel), 32'd0);
            check("rst_grant", 32'(os_grant), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_timeout", 32'(os_timeout), 32'd0);
        end
        rst = 1'b1;
        tick(1);
        check("first_grant_dsel", 32'(d_sel), 32'd3);
        check("first_grant_onehot", 32'(os_grant), 32'h4);
        check("first_grant_busy", 32'(busy), 32'd1);
        // os_rep=0 -> one os_sent completes it
        pulse_sent();
        check("zero_rep_done", 32'(os_done), 32'd1);
        check("zero_rep_dsel", 32'(d_sel), 32'd0);
        os_req = 4'd0;
        expect_gap("zero_rep");

        // Basic burst of 3, os_rep change after grant ignored
        os_req = 4'b0100; os_rep = 8'd3;
        tick(1);
        check("basic_dsel", 32'(d_sel), 32'd3);
        os_rep = 8'd1;
        for (int p = 1; p <= 3; p++) begin
            tick(4);
            check("basic_hold_dsel", 32'(d_sel), 32'd3);
            pulse_sent();
            check("basic_done", 32'(os_done), (p == 3) ? 32'd1 : 32'd0);
            check("basic_dsel_after", 32'(d_sel), (p == 3) ? 32'd0 : 32'd3);
        end
        os_req = 4'd0;
        expect_gap("basic");

        // Priority: SLOS2 over TS2 over data
        os_req = 4'b1010; data_req = 1'b1; os_rep = 8'd1;
        tick(1);
        check("prio_dsel_slos2", 32'(d_sel), 32'd2);
        check("prio_grant_slos2", 32'(os_grant), 32'h2);
        check("prio_no_data", 32'(data_active), 32'd0);
        pulse_sent();
        check("prio_done_slos2", 32'(os_done), 32'd1);
        os_req = 4'b1000;
        expect_gap("prio_slos2");
        tick(1);
        check("prio_dsel_ts2", 32'(d_sel), 32'd4);
        check("prio_grant_ts2", 32'(os_grant), 32'h8);
        pulse_sent();
        check("prio_done_ts2", 32'(os_done), 32'd1);
        os_req = 4'd0;
        expect_gap("prio_ts2");
        tick(1);
        check("data_dsel", 32'(d_sel), 32'd8);
        check("data_active", 32'(data_active), 32'd1);
        check("data_busy", 32'(busy), 32'd1);

        // Preemption of data by SLOS1
        os_req = 4'b0001;
        tick(1);
        check("preempt_idle_dsel", 32'(d_sel), 32'd0);
        check("preempt_data_active", 32'(data_active), 32'd0);
        tick(1);
        check("preempt_dsel", 32'(d_sel), 32'd1);
        check("preempt_grant", 32'(os_grant), 32'h1);
        data_req = 1'b0;
        pulse_sent();
        check("preempt_done", 32'(os_done), 32'd1);
        os_req = 4'd0;
        expect_gap("preempt");

        // Abort: os_rep=5, request dropped after 2 sends
        os_req = 4'b0100; os_rep = 8'd5;
        tick(1);
        check("abort_dsel", 32'(d_sel), 32'd3);
        pulse_sent();
        pulse_sent();
        check("abort_not_done", 32'(os_done), 32'd0);
        os_req = 4'd0;
        tick(3);
        check("abort_hold_dsel", 32'(d_sel), 32'd3);
        check("abort_hold_done", 32'(os_done), 32'd0);
        pulse_sent();
        check("abort_done", 32'(os_done), 32'd1);
        expect_gap("abort");

        // Watchdog on a TS2 burst with no os_sent
        os_req = 4'b1000; os_rep = 8'd1;
        tick(1);
        check("wd_dsel", 32'(d_sel), 32'd4);
`ifdef OS_TIMEOUT_EN
        tick(TMO - 1);
        check("wd_before_dsel", 32'(d_sel), 32'd4);
        check("wd_before_flag", 32'(os_timeout), 32'd0);
        tick(1);
        check("wd_flag", 32'(os_timeout), 32'd1);
        check("wd_done", 32'(os_done), 32'd1);
        check("wd_dsel_cleared", 32'(d_sel), 32'd0);
        os_req = 4'd0;
        expect_gap("wd");
        check("wd_sticky", 32'(os_timeout), 32'd1);
`else
        for (int i = 0; i < 4; i++) begin
            tick(50);
            check("nowd_dsel", 32'(d_sel), 32'd4);
            check("nowd_flag", 32'(os_timeout), 32'd0);
        end
        pulse_sent();
        check("nowd_done", 32'(os_done), 32'd1);
        os_req = 4'd0;
        expect_gap("nowd");
`endif

        // Randomized bursts against the transaction model
        for (int t = 0; t < 25; t++) begin
            req      = 4'($urandom_range(1, 15));
            os_rep   = REP_W'($urandom_range(0, 6));
            dreq     = 1'($urandom_range(0, 1));
            abort_at = int'($urandom_range(1, 8));
            idx      = lowest_idx(req);
            need     = (os_rep == '0) ? 1 : int'(os_rep);
            eff      = (abort_at < need) ? abort_at : need;
            os_req   = req;
            data_req = dreq;
            tick(1);
            check("rnd_grant_dsel", 32'(d_sel), 32'(idx + 1));
            check("rnd_grant_onehot", 32'(os_grant), 32'd1 << idx);
            os_rep = REP_W'($urandom_range(0, 255));
            for (int s = 1; s <= eff; s++) begin
                if (s == abort_at) os_req = 4'd0;
                tick(int'($urandom_range(0, 3)));
                pulse_sent();
                check("rnd_done", 32'(os_done), (s == eff) ? 32'd1 : 32'd0);
            end
            os_req = 4'd0;
            expect_gap("rnd");
            if (dreq) begin
                tick(1);
                check("rnd_data_dsel", 32'(d_sel), 32'd8);
                check("rnd_data_active", 32'(data_active), 32'd1);
                data_req = 1'b0;
                tick(1);
                check("rnd_data_release", 32'(d_sel), 32'd0);
                check("rnd_data_busy", 32'(busy), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/os_tx_scheduler.md
Name: os_tx_scheduler

Overview:
- Sequencer and arbiter in front of the lane transmit data bus.
- Takes ordered-set burst requests (SLOS1, SLOS2, TS1, TS2) from the lane-training FSM and a transport-data request, and decides which one owns the bus.
- Drives d_sel to the data bus and counts os_sent completions until each burst finishes.
- Enforces a programmable idle gap between bursts.

Parameters:
- REP_W, 8, width of the repetition count (1..2^REP_W-1 ordered sets per burst).
- GAP_CYCLES, 2, idle cycles (d_sel=0) inserted after every OS burst; 0 means no gap.
- TIMEOUT_CYCLES, 64, os_sent watchdog limit; used only with OS_TIMEOUT_EN.

Ports:
- fsm_clk  in  1  single clock for the block.
- rst  in  1  synchronous, active-low reset.
- os_req  in  4  one-hot/multi-hot burst request, bit0=SLOS1, bit1=SLOS2, bit2=TS1, bit3=TS2; level, held until os_done.
- os_rep  in  REP_W  number of ordered sets in the burst; sampled at grant.
- data_req  in  1  transport layer requests the bus for data; level.
- os_sent  in  1  one-cycle pulse from the data bus when one complete ordered set has left both lanes.
- d_sel  out  4  data bus select: 0 idle, 1 SLOS1, 2 SLOS2, 3 TS1, 4 TS2, 8 transport data.
- os_grant  out  4  one-hot, equals the bit of the burst currently being sent.
- os_done  out  1  one-cycle pulse when the granted burst completes (or is aborted).
- data_active  out  1  high while d_sel=8.
- busy  out  1  high in any state other than IDLE.
- os_timeout  out  1  sticky watchdog flag; constant 0 without OS_TIMEOUT_EN.

Behaviour:
- Reset (rst=0 at a fsm_clk edge): state IDLE; d_sel=0; os_grant=0; os_done=0; data_active=0; busy=0; os_timeout=0; counters=0. All outputs are registered.
- Priority on grant: os_req beats data_req. Within os_req, the lowest set bit wins (SLOS1 > SLOS2 > TS1 > TS2).
- IDLE:
  - If os_req!=0: latch the winning bit and os_rep into rep_cnt, then go to SEND. d_sel and os_grant take the new value on the same edge, so they are valid 1 cycle after request.
  - Else if data_req=1: go to DATA; d_sel=8 and data_active=1 on that edge.
- os_rep=0 at grant: treated as 1 (at least one OS is always sent).
- SEND:
  - d_sel is held at the granted code.
  - Each os_sent pulse decrements rep_cnt.
  - When os_sent arrives with rep_cnt=1: os_done pulses for 1 cycle on the following edge, d_sel=0, os_grant=0. Go to GAP if GAP_CYCLES>0, else IDLE.
  - os_sent in IDLE, GAP or DATA is ignored.
- SEND abort: if the granted os_req bit drops before completion, the block finishes the current ordered set (waits for the next os_sent), then pulses os_done and goes to GAP/IDLE. No new grant happens mid-set.
- A change in os_rep after grant is ignored.
- GAP: d_sel=0 for exactly GAP_CYCLES cycles, then IDLE. Requests are not granted during GAP; re-arbitration happens in IDLE.
- DATA:
  - d_sel=8 while data_req=1.
  - If data_req=0: go to IDLE, d_sel=0 on the next edge.
  - If os_req!=0 while in DATA: preempt. Go to IDLE for one cycle (d_sel=0), then grant the OS. Data resumes only after the burst and gap.
- Simultaneous os_req rise and data_req rise in IDLE: the OS is granted; data waits.
- os_done and a new grant never occur on the same edge (minimum 1 IDLE cycle between them).
- Reset mid-burst: immediate return to IDLE with all outputs at reset values. The counter is discarded; no os_done pulse.

Optional Feature:
- Macro: OS_TIMEOUT_EN.
- With the macro:
  - A cycle counter runs in SEND and clears on each os_sent.
  - When it reaches TIMEOUT_CYCLES: set os_timeout (sticky until reset), pulse os_done, force d_sel=0, go to GAP.
- Without the macro: no counter is built, SEND waits for os_sent indefinitely, and os_timeout is tied to 0.

Test Plan:
- Reset: hold rst=0 for 3 cycles with os_req=4'b0100 -> d_sel=0, os_grant=0, busy=0 throughout; first grant occurs 1 cycle after rst=1.
- Basic burst: os_req=TS1, os_rep=3, three os_sent pulses spaced 5 cycles apart -> d_sel=3 until the third pulse; os_done 1 cycle after it; d_sel=0 for 2 cycles (GAP), then busy=0.
- Priority: os_req=4'b1010 and data_req=1 on the same edge -> SLOS2 granted (d_sel=2, os_grant=4'b0010); after SLOS2 completes and its request is dropped, TS2 is granted; data (d_sel=8) only after the TS2 burst and its gap.
- Preemption: data_req=1 gives d_sel=8; raise os_req=SLOS1 -> next cycle d_sel=0, following cycle d_sel=1; data_active falls with d_sel leaving 8.
- Abort and zero reps: os_rep=0 -> exactly one os_sent needed for os_done. With os_rep=5, drop os_req after 2 sends -> os_done on the 3rd os_sent.
- Watchdog (OS_TIMEOUT_EN, TIMEOUT_CYCLES=64): grant TS2 with no os_sent -> at cycle 64 os_timeout=1, os_done pulses, d_sel=0. Without the macro, d_sel stays 4 for 200 cycles and os_timeout=0.
